seq_timing_gen: RTL and testbench
=================================

# seq_timing_gen

Parametrised sequence-counter and timing generator for the basic-computer control unit. It holds the sequence counter (SC), decodes it into one-hot timing signals T, and latches and decodes the opcode into one-hot D. It issues CLR/INC to SC from a per-opcode end-of-instruction table plus an external clear, replacing the fixed hard-wired clear equation. It adds run/halt control and overrun detection.

## Interface

- SCW, default 4: SC width; NT = 2**SCW timing states.
- OPW, default 3: opcode width; ND = 2**OPW decoded lines.
- LAST_T, default 32'h06544555 (ND*SCW bits): field i (bits i*SCW +: SCW) is the T index at which opcode i auto-clears SC.
  - A field value of 0 disables auto-clear for that opcode.
  - The default encodes D0–D2:T5, D3:T4, D4:T4, D5:T5, D6:T6, D7:none.

- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: leave HALTED and begin at T0.
- halt_req, in, 1: enter HALTED (HLT instruction).
- ext_clr, in, 1: external SC clear (register-ref/IO completion, interrupt entry).
- op_load, in, 1: latch opcode (issued at T2 by control).
- opcode, in, OPW: opcode bits from IR.
- T, out, NT: one-hot decode of SC while RUN; all zero while HALTED.
- D, out, ND: one-hot decode of latched opcode register.
- sc, out, SCW: current SC value.
- clr_o, out, 1: SC clears at the next edge (combinational).
- inc_o, out, 1: SC increments at the next edge (combinational).
- running, out, 1: 1 in RUN state.
- ovf, out, 1: sticky overrun flag.

## Operation

- State machine with two states, HALTED and RUN. Reset enters HALTED.
- HALTED:
  - sc = 0, T = 0, clr_o = inc_o = 0.
  - ext_clr and op_load are ignored.
  - start → RUN.
- RUN:
  - halt_req → HALTED. sc ← 0 and op_valid ← 0. halt_req wins over start, ext_clr and auto-clear.
- Opcode register op_reg (OPW bits) and op_valid flag:
  - op_load in RUN with clr_o = 0: op_reg ← opcode, op_valid ← 1.
  - op_load in a cycle with clr_o = 1 is ignored.
  - D = one-hot(op_reg) at all times.
- Auto-clear condition: op_valid & (LAST_T[op_reg] != 0) & (sc == LAST_T[op_reg]).
- clr_o = running & (ext_clr | auto-clear). inc_o = running & ~clr_o. Exactly one of clr_o/inc_o is high while RUN.
- SC update in RUN without halt_req:
  - clr_o: sc ← 0, op_valid ← 0.
  - inc_o: sc ← sc + 1, modulo NT.
- Overrun: inc_o with sc == NT-1 wraps sc to 0 and sets ovf. ovf stays set until rst.
- Reset values: state HALTED, sc 0, op_reg 0, op_valid 0, ovf 0. Therefore T = 0, D = 1 (D0), running = 0, clr_o = 0, inc_o = 0.

## Timing

- start sampled at edge n → running = 1 and T[0] = 1 from cycle n+1.
- SC advances one state per clock. T is purely combinational from sc and state; no extra register stage.
- op_load at edge n (sc = k) → op_reg and D valid from cycle n+1. Auto-clear can first fire at sc = k+1.
- An instruction whose LAST_T = L occupies T0..TL. T0 of the next instruction follows TL directly, with no bubble.
- halt_req at edge n → running = 0 and T = 0 from cycle n+1.
- rst mid-instruction → all reset values from the next cycle. rst overrides every other input.
- ext_clr and auto-clear in the same cycle → a single clear, identical to either alone.

## Test plan

- Reset, then start → T0..T5 in successive cycles with D = 8'h01. After rst alone, running = 0, T = 0, D = 8'h01, ovf = 0.
- start; op_load with opcode 3'd4 at T2 → D = 8'h10 from T3. clr_o = 1 at T4. The next cycle is T0 with op_valid cleared.
- Opcode 3'd6 loaded at T2 → clear at T6 (sequence T0–T6, 7 cycles). Back-to-back opcode 3'd0 → clear at T5, with no idle cycle between instructions.
- Opcode 3'd7 loaded, no ext_clr → SC counts to T15, wraps to T0 and ovf = 1. Repeat with ext_clr at T3 → sc = 0 next cycle and ovf unchanged.
- halt_req at T3 together with start and ext_clr → running = 0, sc = 0, T = 0 next cycle. ext_clr and op_load while halted → no change. start → T0.
- op_load in the same cycle as auto-clear at T5 → op_reg unchanged and op_valid = 0. rst asserted at T4 → all reset values on the next cycle.

Source files
------------

// File: rtl/seq_timing_gen.sv
// Sequence counter and timing generator for the basic-computer control unit.
// Decodes SC into one-hot T and the latched opcode into one-hot D, with run/halt and overrun.
module seq_timing_gen #(
  parameter int SCW = 4,
  parameter int OPW = 3,
  parameter logic [(2**OPW)*SCW-1:0] LAST_T = 32'h06544555
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt_req,
  input  logic                ext_clr,
  input  logic                op_load,
  input  logic [OPW-1:0]      opcode,
  output logic [(2**SCW)-1:0] T,
  output logic [(2**OPW)-1:0] D,
  output logic [SCW-1:0]      sc,
  output logic                clr_o,
  output logic                inc_o,
  output logic                running,
  output logic                ovf
);

  localparam int NT = 2**SCW;
  localparam int ND = 2**OPW;

  typedef enum logic {S_HALTED = 1'b0, S_RUN = 1'b1} state_t;

  state_t         r_state;
  logic [SCW-1:0] r_sc;
  logic [OPW-1:0] r_op;
  logic           r_op_valid;
  logic           r_ovf;

  logic [SCW-1:0] w_last;
  logic           w_auto;
  logic           w_run;
  logic           w_clr;
  logic           w_inc;
  logic [NT-1:0]  w_T;
  logic [ND-1:0]  w_D;

  // A zero table entry means the opcode relies on ext_clr to end its instruction.
  assign w_last = LAST_T[r_op*SCW +: SCW];
  assign w_auto = r_op_valid && (w_last != '0) && (r_sc == w_last);
  assign w_run  = (r_state == S_RUN);
  assign w_clr  = w_run && (ext_clr || w_auto);
  assign w_inc  = w_run && !w_clr;

  always_comb begin
    w_T = '0;
    if (w_run) w_T[r_sc] = 1'b1;
  end

  always_comb begin
    w_D = '0;
    w_D[r_op] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_HALTED;
      r_sc       <= '0;
      r_op       <= '0;
      r_op_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (halt_req) begin
            r_state    <= S_HALTED;
            r_sc       <= '0;
            r_op_valid <= 1'b0;
          end else if (w_clr) begin
            // An op_load coinciding with the clear belongs to no instruction and is dropped.
            r_sc       <= '0;
            r_op_valid <= 1'b0;
          end else begin
            r_sc <= r_sc + SCW'(1);
            if (r_sc == {SCW{1'b1}}) r_ovf <= 1'b1;
            if (op_load) begin
              r_op       <= opcode;
              r_op_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_HALTED;
      endcase
    end
  end

  assign T       = w_T;
  assign D       = w_D;
  assign sc      = r_sc;
  assign clr_o   = w_clr;
  assign inc_o   = w_inc;
  assign running = w_run;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_seq_timing_gen.sv
// Directed table-driven bench for seq_timing_gen: each row drives one cycle of inputs
// and states the outputs expected in that cycle before the next rising edge.
module tb_seq_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt_req, ext_clr, op_load;
  logic [2:0]  opcode;
  logic [15:0] T;
  logic [7:0]  D;
  logic [3:0]  sc;
  logic        clr_o, inc_o, running, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  seq_timing_gen dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .ext_clr(ext_clr),
    .op_load(op_load), .opcode(opcode), .T(T), .D(D), .sc(sc),
    .clr_o(clr_o), .inc_o(inc_o), .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, hr, ec, ol;
    logic [2:0] opc;
    logic [3:0] esc;
    logic [7:0] ed;
    logic       eclr, einc, erun, eovf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, hr, ec, ol, input logic [2:0] opc,
                     input logic [3:0] esc, input logic [7:0] ed,
                     input logic eclr, einc, erun, eovf);
    vec_t v;
    v.st = st; v.hr = hr; v.ec = ec; v.ol = ol; v.opc = opc;
    v.esc = esc; v.ed = ed; v.eclr = eclr; v.einc = einc; v.erun = erun; v.eovf = eovf;
    vq.push_back(v);
  endtask

  // Running row: exactly one of clr/inc is expected high.
  task automatic rr(input logic ec, ol, input logic [2:0] opc, input logic [3:0] esc,
                    input logic [7:0] ed, input logic eclr, eovf);
    add(1'b0, 1'b0, ec, ol, opc, esc, ed, eclr, ~eclr, 1'b1, eovf);
  endtask

  task automatic check(input string name, input logic [3:0] esc, input logic [7:0] ed,
                       input logic eclr, einc, erun, eovf);
    logic [15:0] et;
    logic [31:0] got, exp;
    et  = erun ? (16'h0001 << esc) : 16'h0000;
    got = {sc, T, D, clr_o, inc_o, running, ovf};
    exp = {esc, et, ed, eclr, einc, erun, eovf};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sc=%0d T=%h D=%h clr=%b inc=%b run=%b ovf=%b, want sc=%0d T=%h D=%h clr=%b inc=%b run=%b ovf=%b",
               name, sc, T, D, clr_o, inc_o, running, ovf, esc, et, ed, eclr, einc, erun, eovf);
    end
  endtask

  task automatic drive(input logic st, hr, ec, ol, input logic [2:0] opc);
    start = st; halt_req = hr; ext_clr = ec; op_load = ol; opcode = opc;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 3'd0);

    // Halted row then instruction with opcode 4 (ends at T4).
    add(1, 0, 0, 0, 3'd0, 4'd0, 8'h01, 0, 0, 0, 0);
    rr(0, 0, 3'd0, 4'd0, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd1, 8'h01, 0, 0);
    rr(0, 1, 3'd4, 4'd2, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd3, 8'h10, 0, 0);
    rr(0, 0, 3'd0, 4'd4, 8'h10, 1, 0);
    // Opcode 6 ends at T6, no bubble before next T0.
    rr(0, 0, 3'd0, 4'd0, 8'h10, 0, 0);
    rr(0, 0, 3'd0, 4'd1, 8'h10, 0, 0);
    rr(0, 1, 3'd6, 4'd2, 8'h10, 0, 0);
    for (int i = 3; i <= 5; i++) rr(0, 0, 3'd0, 4'(i), 8'h40, 0, 0);
    rr(0, 0, 3'd0, 4'd6, 8'h40, 1, 0);
    // Opcode 0 ends at T5.
    rr(0, 0, 3'd0, 4'd0, 8'h40, 0, 0);
    rr(0, 0, 3'd0, 4'd1, 8'h40, 0, 0);
    rr(0, 1, 3'd0, 4'd2, 8'h40, 0, 0);
    rr(0, 0, 3'd0, 4'd3, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd4, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd5, 8'h01, 1, 0);
    // Opcode 4 with ext_clr coinciding with its auto-clear at T4.
    rr(0, 0, 3'd0, 4'd0, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd1, 8'h01, 0, 0);
    rr(0, 1, 3'd4, 4'd2, 8'h01, 0, 0);
    rr(0, 0, 3'd0, 4'd3, 8'h10, 0, 0);
    rr(1, 0, 3'd0, 4'd4, 8'h10, 1, 0);
    // Opcode 7 has no auto-clear: counts to T15 and wraps with overrun.
    rr(0, 0, 3'd0, 4'd0, 8'h10, 0, 0);
    rr(0, 0, 3'd0, 4'd1, 8'h10, 0, 0);
    rr(0, 1, 3'd7, 4'd2, 8'h10, 0, 0);
    for (int i = 3; i <= 15; i++) rr(0, 0, 3'd0, 4'(i), 8'h80, 0, 0);
    rr(0, 0, 3'd0, 4'd0, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd1, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd2, 8'h80, 0, 1);
    rr(1, 0, 3'd0, 4'd3, 8'h80, 1, 1);
    // halt_req with start and ext_clr at T3; halted ignores ext_clr/op_load.
    rr(0, 0, 3'd0, 4'd0, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd1, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd2, 8'h80, 0, 1);
    add(1, 1, 1, 0, 3'd0, 4'd3, 8'h80, 1, 0, 1, 1);
    add(0, 0, 1, 1, 3'd2, 4'd0, 8'h80, 0, 0, 0, 1);
    add(0, 0, 0, 0, 3'd0, 4'd0, 8'h80, 0, 0, 0, 1);
    add(1, 0, 0, 0, 3'd0, 4'd0, 8'h80, 0, 0, 0, 1);
    // op_load coinciding with auto-clear at T5 is dropped; op_valid stays clear afterwards.
    rr(0, 0, 3'd0, 4'd0, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd1, 8'h80, 0, 1);
    rr(0, 1, 3'd0, 4'd2, 8'h80, 0, 1);
    rr(0, 0, 3'd0, 4'd3, 8'h01, 0, 1);
    rr(0, 0, 3'd0, 4'd4, 8'h01, 0, 1);
    rr(0, 1, 3'd3, 4'd5, 8'h01, 1, 1);
    for (int i = 0; i <= 6; i++) rr(0, 0, 3'd0, 4'(i), 8'h01, 0, 1);

    // Reset alone.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("reset", 4'd0, 8'h01, 0, 0, 0, 0);

    foreach (vq[i]) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].st, vq[i].hr, vq[i].ec, vq[i].ol, vq[i].opc);
      #1 check($sformatf("row%0d", i), vq[i].esc, vq[i].ed, vq[i].eclr, vq[i].einc,
               vq[i].erun, vq[i].eovf);
    end

    // sc is now 7: ext_clr back to T0, load opcode 3 (ends T4), rst at T4.
    @(negedge clk);
    drive(0, 0, 1, 0, 3'd0);
    #1 check("ext_clr_t7", 4'd7, 8'h01, 1, 0, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 3'd0);
    #1 check("after_clr", 4'd0, 8'h01, 0, 1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1, 3'd3);
    #1 check("load3", 4'd2, 8'h01, 0, 1, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 3'd0);
    #1 check("d3_t3", 4'd3, 8'h08, 0, 1, 1, 1);
    @(negedge clk);
    drive(1, 0, 1, 1, 3'd5);
    rst = 1'b1;
    #1 check("t4_clr", 4'd4, 8'h08, 1, 0, 1, 1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 3'd0);
    #1 check("mid_rst", 4'd0, 8'h01, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 3'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 3'd0);
    #1 check("restart", 4'd0, 8'h01, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
